// File: rtl/fsm_controller.sv
// Keypad row-sense and debounce controller on the slow scan clock.
// Detects a single active row, latches it together with the column drive
// pattern, and raises key_pressed once the row stays stable long enough.
module fsm_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  input  logic [3:0] col_shift_reg,
  output logic [3:0] row_capture,
  output logic       key_pressed
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    DEBOUNCE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES);

  state_e           current_state, next_state;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       row_capture_d;
  logic             key_pressed_d;

  // Next-state, candidate/column latch, counter and registered-output logic.
  always_comb begin
    next_state    = current_state;
    cand_d        = cand_q;
    col_d         = col_q;
    cnt_d         = cnt_q;
    row_capture_d = row_capture;
    key_pressed_d = key_pressed;

    case (current_state)
      IDLE: begin
        key_pressed_d = 1'b0;
        if (row_in != 4'b0000) next_state = SCAN;
      end

      SCAN: begin
        key_pressed_d = 1'b0;
        if ($onehot(row_in)) begin
          cand_d     = row_in;
          col_d      = col_shift_reg;
          cnt_d      = '0;
          next_state = DEBOUNCE;
        end else begin
          // Glitch (no row) or ghosting (several rows): start over.
          next_state = IDLE;
        end
      end

      DEBOUNCE: begin
        if (row_in == 4'b0000) begin
          next_state    = IDLE;
          key_pressed_d = 1'b0;
        end else if ((row_in != cand_q) || (col_shift_reg != col_q)) begin
          // Bounce or column change: abandon without touching row_capture.
          next_state    = IDLE;
          key_pressed_d = 1'b0;
        end else begin
          if (cnt_q != CntMax) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CntMax) begin
            row_capture_d = cand_q;
            key_pressed_d = 1'b1;
          end
        end
      end

      default: begin
        // Unreachable encoding: recover to IDLE with everything cleared.
        next_state    = IDLE;
        cand_d        = 4'b0000;
        col_d         = 4'b0000;
        cnt_d         = '0;
        row_capture_d = 4'b0000;
        key_pressed_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      current_state <= IDLE;
      cand_q        <= 4'b0000;
      col_q         <= 4'b0000;
      cnt_q         <= '0;
      row_capture   <= 4'b0000;
      key_pressed   <= 1'b0;
    end else begin
      current_state <= next_state;
      cand_q        <= cand_d;
      col_q         <= col_d;
      cnt_q         <= cnt_d;
      row_capture   <= row_capture_d;
      key_pressed   <= key_pressed_d;
    end
  end

endmodule

// File: tb/tb_fsm_controller.sv
// Directed self-checking bench for fsm_controller (DEBOUNCE_CYCLES = 2).
module tb_fsm_controller;

  localparam logic [1:0] SIdle = 2'd0;
  localparam logic [1:0] SScan = 2'd1;
  localparam logic [1:0] SDeb  = 2'd2;

  logic       slow_clk;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_shift_reg;
  logic [3:0] row_capture;
  logic       key_pressed;

  int n_checks = 0;
  int n_errors = 0;

  fsm_controller #(
    .DEBOUNCE_CYCLES(2),
    .CNT_W          (8)
  ) dut (
    .slow_clk     (slow_clk),
    .rst          (rst),
    .row_in       (row_in),
    .col_shift_reg(col_shift_reg),
    .row_capture  (row_capture),
    .key_pressed  (key_pressed)
  );

  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic [3:0] rc,
                            input logic kp);
    check_eq({tag, ".state"}, 32'(dut.current_state), 32'(st));
    check_eq({tag, ".row_capture"}, 32'(row_capture), 32'(rc));
    check_eq({tag, ".key_pressed"}, 32'(key_pressed), 32'(kp));
  endtask

  // Advance one clock edge and settle before sampling.
  task automatic step();
    @(posedge slow_clk);
    #1;
  endtask

  initial begin
    rst           = 1'b0;
    row_in        = 4'b0000;
    col_shift_reg = 4'b0000;
    #1;
    expect_out("rst_t0", SIdle, 4'b0000, 1'b0);

    // Reset held for 10 clocks
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out("rst_hold", SIdle, 4'b0000, 1'b0);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      expect_out("idle", SIdle, 4'b0000, 1'b0);
    end

    // Valid press: row 0010, 6 clocks
    row_in = 4'b0010;
    step(); expect_out("press_e1", SScan, 4'b0000, 1'b0);
    step(); expect_out("press_e2", SDeb,  4'b0000, 1'b0);
    step(); expect_out("press_e3", SDeb,  4'b0000, 1'b0);
    step(); expect_out("press_e4", SDeb,  4'b0010, 1'b1);
    step(); expect_out("press_e5", SDeb,  4'b0010, 1'b1);
    step(); expect_out("press_e6", SDeb,  4'b0010, 1'b1);

    // Release: sticky row_capture
    row_in = 4'b0000;
    step(); expect_out("release_e1", SIdle, 4'b0010, 1'b0);
    step(); expect_out("release_e2", SIdle, 4'b0010, 1'b0);

    // Short bounce
    row_in = 4'b0100;
    step(); expect_out("bounce_e1", SScan, 4'b0010, 1'b0);
    step(); expect_out("bounce_e2", SDeb,  4'b0010, 1'b0);
    row_in = 4'b0000;
    step(); expect_out("bounce_e3", SIdle, 4'b0010, 1'b0);

    // Ghosting: multi-row never enters DEBOUNCE
    row_in = 4'b0110;
    for (int i = 0; i < 2; i++) begin
      step(); expect_out("ghost_scan", SScan, 4'b0010, 1'b0);
      step(); expect_out("ghost_idle", SIdle, 4'b0010, 1'b0);
    end
    row_in = 4'b0000;
    step(); expect_out("ghost_done", SIdle, 4'b0010, 1'b0);

    // Abort on row change
    row_in = 4'b0001;
    step(); expect_out("abort_row_e1", SScan, 4'b0010, 1'b0);
    step(); expect_out("abort_row_e2", SDeb,  4'b0010, 1'b0);
    row_in = 4'b1000;
    step(); expect_out("abort_row_e3", SIdle, 4'b0010, 1'b0);
    row_in = 4'b0000;
    step(); expect_out("abort_row_e4", SIdle, 4'b0010, 1'b0);

    // Abort on column change
    row_in = 4'b0001;
    step(); expect_out("abort_col_e1", SScan, 4'b0010, 1'b0);
    step(); expect_out("abort_col_e2", SDeb,  4'b0010, 1'b0);
    step(); expect_out("abort_col_e3", SDeb,  4'b0010, 1'b0);
    col_shift_reg = 4'b0001;
    step(); expect_out("abort_col_e4", SIdle, 4'b0010, 1'b0);
    row_in = 4'b0000;
    step(); expect_out("abort_col_e5", SIdle, 4'b0010, 1'b0);

    // New accepted key with nonzero column, held long
    row_in        = 4'b1000;
    col_shift_reg = 4'b0011;
    step(); expect_out("key2_e1", SScan, 4'b0010, 1'b0);
    step(); expect_out("key2_e2", SDeb,  4'b0010, 1'b0);
    step(); expect_out("key2_e3", SDeb,  4'b0010, 1'b0);
    step(); expect_out("key2_e4", SDeb,  4'b1000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(); expect_out("key2_hold", SDeb, 4'b1000, 1'b1);
    end

    // Async reset between edges, mid-DEBOUNCE
    #2;
    rst = 1'b0;
    #1;
    expect_out("async_rst", SIdle, 4'b0000, 1'b0);
    step(); expect_out("async_rst_hold", SIdle, 4'b0000, 1'b0);
    row_in = 4'b0000;
    rst    = 1'b1;
    step(); expect_out("post_rst", SIdle, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
